// File: rtl/weight_fetch_sequencer_if.sv
// Handshake/bus bundle between the weight fetch sequencer, the layer
// controller, the weight ROM and the MAC array.
interface weight_fetch_sequencer_if #(
  parameter int N      = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [N-1:0]      rom_data;
  logic [N-1:0]      w_data;
  logic              w_valid;
  logic              w_ready;
  logic [7:0]        w_neuron;
  logic              w_last_in;
  logic              w_last;

  // sequencer side
  modport master (
    input  start, rom_data, w_ready,
    output busy, done, rom_addr, w_data, w_valid, w_neuron, w_last_in, w_last
  );

  // controller / ROM / MAC side
  modport slave (
    output start, rom_data, w_ready,
    input  busy, done, rom_addr, w_data, w_valid, w_neuron, w_last_in, w_last
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Walks the weight ROM of one fully-connected layer (input fastest, then
// neuron) and streams the weights to the MAC array. A 2-entry output FIFO
// plus a one-read-in-flight credit scheme hides the ROM read latency and
// absorbs MAC backpressure without losing or duplicating words.
module weight_fetch_sequencer #(
  parameter int N         = 8,
  parameter int Q         = 7,
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 16,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  weight_fetch_sequencer_if.master bus
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // Q is only carried for datapath consistency; reject nonsense configs.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("weight_fetch_sequencer: Q must be in [0, N-1]");
  end
  if (NUM_IN < 1 || NUM_OUT < 1 || NUM_OUT > 256) begin : g_bad_dims
    $error("weight_fetch_sequencer: NUM_IN>=1, 1<=NUM_OUT<=256 required");
  end
  if (BASE_ADDR + NUM_IN * NUM_OUT > (1 << ADDR_W)) begin : g_bad_addr
    $error("weight_fetch_sequencer: layer does not fit in ROM address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [7:0] neuron;
    logic       last_in;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [N-1:0] data;
    tag_t         tag;
  } word_t;

  state_t            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [IW-1:0]     in_cnt_q;
  logic [7:0]        nrn_cnt_q;
  logic              infl_q;
  tag_t              infl_tag_q;
  word_t             mem_q [2];
  logic              wr_q, rd_q;
  logic [1:0]        occ_q;

  logic       pop, issue, is_last_in, is_last_nrn, drain_done;
  logic [1:0] used;

  // A word leaving this cycle frees its slot for an issue in the same cycle,
  // which is what sustains one weight per cycle under full throughput.
  assign pop         = (occ_q != 2'd0) & bus.w_ready;
  assign used        = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign is_last_in  = (in_cnt_q == IW'(NUM_IN - 1));
  assign is_last_nrn = (nrn_cnt_q == 8'(NUM_OUT - 1));
  assign issue       = (state_q == S_RUN) & (used < 2'd2);
  assign drain_done  = (state_q == S_DRAIN) & ~infl_q &
                       ((occ_q == 2'd0) | ((occ_q == 2'd1) & pop));

  // Layer FSM: start/busy/done handshake with the layer controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start && !done_q) begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
        S_RUN: if (issue && is_last_in && is_last_nrn) state_q <= S_DRAIN;
        S_DRAIN: if (drain_done) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Address/index counters; tags of the in-flight read travel with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= ADDR_W'(BASE_ADDR);
      in_cnt_q   <= '0;
      nrn_cnt_q  <= '0;
      infl_q     <= 1'b0;
      infl_tag_q <= '0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        // counters wrap to 0 after the final issue, so (0,0) marks a new sweep
        rom_addr_q <= (in_cnt_q == '0 && nrn_cnt_q == '0) ? ADDR_W'(BASE_ADDR)
                                                          : rom_addr_q + 1'b1;
        infl_tag_q <= '{neuron: nrn_cnt_q, last_in: is_last_in,
                        last: is_last_in & is_last_nrn};
        if (is_last_in) begin
          in_cnt_q  <= '0;
          nrn_cnt_q <= is_last_nrn ? 8'd0 : nrn_cnt_q + 8'd1;
        end else begin
          in_cnt_q  <= in_cnt_q + 1'b1;
        end
      end
    end
  end

  // 2-entry output FIFO; the ROM word lands one cycle after its issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (infl_q) begin
        mem_q[wr_q] <= '{data: bus.rom_data, tag: infl_tag_q};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.w_valid   = (occ_q != 2'd0);
  assign bus.w_data    = mem_q[rd_q].data;
  assign bus.w_neuron  = mem_q[rd_q].tag.neuron;
  assign bus.w_last_in = mem_q[rd_q].tag.last_in;
  assign bus.w_last    = mem_q[rd_q].tag.last;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: a 4x2 layer with random backpressure and
// a scoreboard fed by a layer-level reference model, plus a 1x1 layer.
module tb_weight_fetch_sequencer;

  localparam int NI = 4, NO = 2, BASE = 'h10;
  localparam int BASE_B = 'h20;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] neuron;
    logic       last_in;
    logic       last;
  } exp_t;

  logic clk, rst;
  weight_fetch_sequencer_if #(.N(8), .ADDR_W(8)) ifa ();
  weight_fetch_sequencer_if #(.N(8), .ADDR_W(8)) ifb ();

  weight_fetch_sequencer #(.N(8), .Q(7), .NUM_IN(NI), .NUM_OUT(NO),
    .BASE_ADDR(BASE), .ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));

  weight_fetch_sequencer #(.N(8), .Q(7), .NUM_IN(1), .NUM_OUT(1),
    .BASE_ADDR(BASE_B), .ADDR_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  int   total = 0, bad = 0;
  int   done_cnt = 0, acc_cnt = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];
  exp_t cur, e, prev_word;
  logic prev_stall = 0, prev_last = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ROM models: registered on the falling edge
  always @(negedge clk) ifa.rom_data <= ifa.rom_addr;
  always @(negedge clk) ifb.rom_data <= ifb.rom_addr ^ 8'h5A;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, expv, $time);
    end
  endtask

  // reference: whole layer in ROM order, ROM[a]=a
  task automatic push_sweep();
    for (int n = 0; n < NO; n++)
      for (int i = 0; i < NI; i++) begin
        exp_t w;
        int a = BASE + n * NI + i;
        w.data    = a[7:0];
        w.neuron  = n[7:0];
        w.last_in = (i == NI - 1);
        w.last    = (i == NI - 1) && (n == NO - 1);
        exp_q.push_back(w);
      end
  endtask

  // MAC ready generator
  initial begin
    int cyc = 0;
    ifa.w_ready = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0: ifa.w_ready = 1;
        1: ifa.w_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: ifa.w_ready = 1'($urandom_range(0, 1));
        default: ifa.w_ready = 0;
      endcase
    end
  end

  // monitor / scoreboard for dut_a
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_last  = 0;
    end else begin
      cur = '{ifa.w_data, ifa.w_neuron, ifa.w_last_in, ifa.w_last};
      if (prev_stall) chk("stall_hold", {ifa.w_valid, cur}, {1'b1, prev_word});
      chk("done_pulse", ifa.done, prev_last);
      if (prev_last) chk("busy_at_done", ifa.busy, 0);
      if (ifa.done) done_cnt++;
      if (ifa.busy)
        chk("addr_range", (ifa.rom_addr >= 8'(BASE)) && (ifa.rom_addr <= 8'(BASE + NI * NO - 1)), 1);
      if (ifa.w_valid && ifa.w_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_word", cur, 0);
        else begin
          e = exp_q.pop_front();
          chk("word", cur, e);
        end
        prev_last = cur.last;
      end else prev_last = 0;
      prev_stall = ifa.w_valid && !ifa.w_ready;
      prev_word  = cur;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 ifa.start = 1;
    @(posedge clk); #1 ifa.start = 0;
  endtask

  task automatic wait_done(input string nm, input int d0, input int bound);
    int t = 0;
    while (done_cnt == d0 && t < bound) begin @(posedge clk); t++; end
    @(posedge clk);
    chk({nm, "_done_count"}, done_cnt, d0 + 1);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, a0, t;
    rst = 1; ifa.start = 0; ifb.start = 0; ifb.w_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {ifa.busy, ifa.done, ifa.w_valid, ifa.w_last_in, ifa.w_last},
        5'b0);
    chk("rst_addr", ifa.rom_addr, BASE);
    chk("rst_data_tags", {ifa.w_data, ifa.w_neuron}, 16'h0);
    @(posedge clk); #1 rst = 0;

    // 1: full throughput, first word two cycles after start is accepted
    rdy_mode = 0; d0 = done_cnt;
    push_sweep();
    pulse_start();
    @(negedge clk); chk("lat_c0", {ifa.busy, ifa.w_valid}, 2'b10);
    @(negedge clk); chk("lat_c1", ifa.w_valid, 0);
    @(negedge clk); chk("lat_c2", ifa.w_valid, 1);
    wait_done("t1", d0, 200);

    // 2: ready pattern 1,0,0,1
    rdy_mode = 1; d0 = done_cnt;
    push_sweep();
    pulse_start();
    wait_done("t2", d0, 300);

    // 3: long stall right after start
    rdy_mode = 3; d0 = done_cnt;
    push_sweep();
    pulse_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_addr", (ifa.rom_addr >= 8'(BASE)) && (ifa.rom_addr <= 8'(BASE + 2)), 1);
    chk("stall_busy", ifa.busy, 1);
    rdy_mode = 0;
    wait_done("t3", d0, 200);

    // 4: reset after the third accepted word
    rdy_mode = 0; d0 = done_cnt; a0 = acc_cnt;
    push_sweep();
    pulse_start();
    t = 0;
    do begin @(posedge clk); t++; end while (acc_cnt < a0 + 3 && t < 100);
    chk("t4_reached_3", acc_cnt >= a0 + 3, 1);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_post_rst", {ifa.busy, ifa.w_valid, ifa.done}, 3'b0);
    chk("t4_post_rst_addr", ifa.rom_addr, BASE);
    repeat (4) @(posedge clk);
    chk("t4_no_done", done_cnt, d0);
    push_sweep();
    pulse_start();
    wait_done("t4_replay", d0, 200);

    // 5: random backpressure, start held/pulsed while busy and in done cycle
    rdy_mode = 2; d0 = done_cnt;
    push_sweep();
    @(posedge clk); #1 ifa.start = 1;
    t = 0;
    forever begin
      @(posedge clk); #1;
      t++;
      if (ifa.done || t > 500) begin
        ifa.start = 1;
        @(posedge clk); #1 ifa.start = 0;
        break;
      end
      ifa.start = 1'($urandom_range(0, 1));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_idle", ifa.busy, 0);
    chk("t5_one_done", done_cnt, d0 + 1);
    chk("t5_queue_empty", exp_q.size(), 0);

    // more random-backpressure sweeps
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      push_sweep();
      pulse_start();
      wait_done("t_rand", d0, 500);
    end

    // 6: single-weight layer
    @(posedge clk); #1 ifb.start = 1;
    @(posedge clk); #1 ifb.start = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!ifb.w_valid && t < 10);
    chk("t6_valid", ifb.w_valid, 1);
    chk("t6_word", {ifb.w_data, ifb.w_neuron, ifb.w_last_in, ifb.w_last},
        {8'(BASE_B ^ 'h5A), 8'h00, 1'b1, 1'b1});
    @(negedge clk);
    chk("t6_done", {ifb.done, ifb.busy, ifb.w_valid}, 3'b100);
    @(negedge clk);
    chk("t6_after", {ifb.done, ifb.busy}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
